// File: rtl/candy_pkg.sv
// Shared constants for the candy machine front end.
//   NUM_KEYS                : number of key lines feeding candy_top key_in
//   KEY_*                   : bit index of each key within key_in
//   DEFAULT_DEBOUNCE_CYCLES : 10 ms at 50 MHz
//   DEFAULT_CNT_W           : counter width able to hold DEFAULT_DEBOUNCE_CYCLES-1
package candy_pkg;

    localparam int unsigned NUM_KEYS   = 4;

    localparam int unsigned KEY_COIN_A = 0;
    localparam int unsigned KEY_COIN_B = 1;
    localparam int unsigned KEY_CANCEL = 2;
    localparam int unsigned KEY_VEND   = 3;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEFAULT_CNT_W           = 19;

endpackage : candy_pkg

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchroniser, stability counter and
// debounced level register.
//   clk, reset : system clock, asynchronous active-low reset
//   raw        : raw button level, asynchronous to clk
//   stable     : debounced level (registered)
//   press_c    : combinational, high on the edge where stable flips 0 -> 1
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = candy_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = candy_pkg::DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] count;
    logic             flip_c;

    // Counter has run out while s2 still disagrees with the accepted level.
    assign flip_c  = (s2 != stable) && (count == CNT_LAST);
    assign press_c = flip_c && s2;

    // Synchroniser; only s2 is used downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any agreement with the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            count  <= '0;
        end else if (flip_c) begin
            count  <= '0;
            stable <= s2;
        end else begin
            count  <= count + CNT_W'(1);
        end
    end

endmodule : key_debounce

// File: rtl/keypad_debounce.sv
// Keypad conditioner for candy_top: debounces every key line independently,
// queues press events and emits them as one-hot, single-cycle pulses, lowest
// index first.
//   clk, reset : system clock, asynchronous active-low reset
//   key_raw    : raw button levels, 1 = pressed, asynchronous to clk
//   key_out    : one-hot press pulse, one clk wide (drives candy_top key_in)
//   key_held   : debounced level per key
//   pend_any   : high while any press is queued but not yet emitted
module keypad_debounce #(
    parameter int unsigned NUM_KEYS        = candy_pkg::NUM_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = candy_pkg::DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = candy_pkg::DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                pend_any
);

    logic [NUM_KEYS-1:0] press_c;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] grant_c;
    logic [NUM_KEYS-1:0] pending_next_c;
    logic                found_c;

    // One conditioner per key line.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .raw     (key_raw[g]),
            .stable  (key_held[g]),
            .press_c (press_c[g])
        );
    end

    // Lowest-index grant; a new press on the granted bit re-queues it.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pending[i] && !found_c) begin
                grant_c[i] = 1'b1;
                found_c    = 1'b1;
            end
        end
        pending_next_c = (pending & ~grant_c) | press_c;
    end

    // pend_any tracks the value pending is about to take, so both agree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            key_out  <= '0;
            pend_any <= 1'b0;
        end else begin
            pending  <= pending_next_c;
            key_out  <= grant_c;
            pend_any <= |pending_next_c;
        end
    end

endmodule : keypad_debounce

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce with a short debounce window.
module tb_keypad_debounce;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_out;
    logic [NK-1:0] key_held;
    logic          pend_any;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_raw  (key_raw),
        .key_out  (key_out),
        .key_held (key_held),
        .pend_any (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] raw;
        logic [NK-1:0] out;
        logic [NK-1:0] held;
        logic          pend;
        int            n;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [NK-1:0] raw, input logic [NK-1:0] out,
                                input logic [NK-1:0] held, input logic pend, input int n);
        vec_t v;
        v.raw  = raw;
        v.out  = out;
        v.held = held;
        v.pend = pend;
        v.n    = n;
        tbl.push_back(v);
    endfunction

    task automatic check4(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [NK-1:0] out,
                             input logic [NK-1:0] held, input logic pend);
        check4({tag, ".key_out"},  key_out,  out);
        check4({tag, ".key_held"}, key_held, held);
        check1({tag, ".pend_any"}, pend_any, pend);
    endtask

    // Drive raw before the edge, sample 1 time unit after it.
    task automatic step(input logic [NK-1:0] raw);
        key_raw = raw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NK-1:0] exp_out;
        logic [NK-1:0] raw;
        int            row;

        // Idle after reset.
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 20);
        // Clean press of key 0: flip 5 edges after first sample, pulse on the 6th.
        add(4'b0001, 4'b0000, 4'b0000, 1'b0, 5);
        add(4'b0001, 4'b0000, 4'b0001, 1'b1, 1);
        add(4'b0001, 4'b0001, 4'b0001, 1'b0, 1);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0, 50);
        add(4'b0000, 4'b0000, 4'b0001, 1'b0, 5);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 10);
        // Simultaneous press of keys 1 and 3.
        add(4'b1010, 4'b0000, 4'b0000, 1'b0, 5);
        add(4'b1010, 4'b0000, 4'b1010, 1'b1, 1);
        add(4'b1010, 4'b0010, 4'b1010, 1'b1, 1);
        add(4'b1010, 4'b1000, 4'b1010, 1'b0, 1);
        add(4'b1010, 4'b0000, 4'b1010, 1'b0, 5);
        add(4'b0000, 4'b0000, 4'b1010, 1'b0, 5);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 5);
        // Press key 0, release for only 3 cycles: no second pulse.
        add(4'b0001, 4'b0000, 4'b0000, 1'b0, 5);
        add(4'b0001, 4'b0000, 4'b0001, 1'b1, 1);
        add(4'b0001, 4'b0001, 4'b0001, 1'b0, 1);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0, 3);
        add(4'b0000, 4'b0000, 4'b0001, 1'b0, 3);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0, 15);
        // Release for 10 cycles, then press again: a second pulse.
        add(4'b0000, 4'b0000, 4'b0001, 1'b0, 5);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 5);
        add(4'b0001, 4'b0000, 4'b0000, 1'b0, 5);
        add(4'b0001, 4'b0000, 4'b0001, 1'b1, 1);
        add(4'b0001, 4'b0001, 4'b0001, 1'b0, 1);
        add(4'b0001, 4'b0000, 4'b0001, 1'b0, 3);
        add(4'b0000, 4'b0000, 4'b0001, 1'b0, 5);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0, 5);

        key_raw = '0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #2;
        check_all("reset_async", 4'b0000, 4'b0000, 1'b0);
        step(4'b0000);
        step(4'b0000);
        check_all("reset_hold", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;

        row = 0;
        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++) begin
                step(tbl[k].raw);
                check_all($sformatf("tbl_row%0d_cyc%0d", row, c), tbl[k].out, tbl[k].held, tbl[k].pend);
            end
            row++;
        end

        // Bounce on key 3: 1,1,0,0,1,1,0,0 then held 1 from cycle 8.
        for (int c = 0; c < 30; c++) begin
            raw = 4'b1000;
            if (c < 8 && ((c / 2) % 2) == 1) raw = 4'b0000;
            step(raw);
            exp_out = (c == 14) ? 4'b1000 : 4'b0000;
            check4($sformatf("bounce_cyc%0d", c), key_out, exp_out);
        end
        check4("bounce_held", key_held, 4'b1000);
        for (int c = 0; c < 10; c++) step(4'b0000);
        check4("bounce_release_held", key_held, 4'b0000);

        // Reset while a four-key queue is draining.
        for (int c = 0; c < 7; c++) step(4'b1111);
        check4("mq_first_pulse", key_out, 4'b0001);
        check1("mq_first_pend", pend_any, 1'b1);
        reset = 1'b0;
        #1;
        check_all("mq_reset_async", 4'b0000, 4'b0000, 1'b0);
        step(4'b1111);
        step(4'b1111);
        check_all("mq_reset_hold", 4'b0000, 4'b0000, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step(4'b1111);
            exp_out = 4'b0000;
            if (c >= 6 && c <= 9) exp_out[c-6] = 1'b1;
            check4($sformatf("mq_redebounce_cyc%0d", c), key_out, exp_out);
        end
        check4("mq_held", key_held, 4'b1111);
        check1("mq_pend_drained", pend_any, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_keypad_debounce
